// File: rtl/enigma_pkg.sv
// Shared constants, FSM encoding and byte-classification helpers for the
// Enigma command parser.
package enigma_pkg;

  localparam int LETTER_W = 5;

  localparam logic [7:0] ASCII_UC_A = 8'h41;
  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_BANG = 8'h21;
  localparam logic [7:0] ASCII_ONE  = 8'h31;

  localparam logic [2:0] CFG_ADDR_POS_L  = 3'd0;
  localparam logic [2:0] CFG_ADDR_POS_M  = 3'd1;
  localparam logic [2:0] CFG_ADDR_POS_R  = 3'd2;
  localparam logic [2:0] CFG_ADDR_RING_L = 3'd3;
  localparam logic [2:0] CFG_ADDR_RING_M = 3'd4;
  localparam logic [2:0] CFG_ADDR_RING_R = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_FIELD, ST_VALUE, ST_APPLY} state_t;

  // Folding bit 5 maps upper case onto lower case; nothing else lands in a..z.
  function automatic logic is_letter(input logic [7:0] b);
    logic [7:0] l;
    l = b | 8'h20;
    return (l >= ASCII_LC_A) && (l <= 8'h7A);
  endfunction

  function automatic logic [LETTER_W-1:0] letter_idx(input logic [7:0] b);
    logic [7:0] d;
    d = (b | 8'h20) - ASCII_LC_A;
    return d[LETTER_W-1:0];
  endfunction

  // Returns {ok, addr} for the field selector byte after '!'.
  function automatic logic [3:0] field_sel(input logic [7:0] b);
    logic [7:0] l;
    l = b | 8'h20;
    if (l == 8'h6C)                    return {1'b1, CFG_ADDR_POS_L};
    else if (l == 8'h6D)               return {1'b1, CFG_ADDR_POS_M};
    else if (l == 8'h72)               return {1'b1, CFG_ADDR_POS_R};
    else if (b == ASCII_ONE)           return {1'b1, CFG_ADDR_RING_L};
    else if (b == ASCII_ONE + 8'd1)    return {1'b1, CFG_ADDR_RING_M};
    else if (b == ASCII_ONE + 8'd2)    return {1'b1, CFG_ADDR_RING_R};
    else                               return 4'b0000;
  endfunction

endpackage

// File: rtl/enigma_cmd_parser_char_fifo.sv
// Synchronous show-ahead FIFO; a simultaneous push and pop both succeed even when full.
module char_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic          w_do_pop, w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign count     = r_count;
  assign rdata     = r_mem[r_rp];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk)
    if (w_do_push) r_mem[r_wp] <= wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/enigma_cmd_parser.sv
// UART-byte parser: queues plaintext letters for the cipher core and turns
// "!<field><letter>" commands into config writes ordered behind queued letters.
module enigma_cmd_parser
  import enigma_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_byte,
  input  logic                rx_valid,
  input  logic                rx_error,
  output logic [LETTER_W-1:0] char_data,
  output logic                char_valid,
  input  logic                char_ready,
  output logic                cfg_wr,
  output logic [2:0]          cfg_addr,
  output logic [LETTER_W-1:0] cfg_data,
  output logic                cmd_error,
  output logic                drop_error,
  output logic                frame_error
);

  // Classification stage, aligned with the registered rx_error edge
  logic                r_s1_vld, r_s1_letter, r_s1_bang, r_s1_fld_ok;
  logic [2:0]          r_s1_fld_addr;
  logic [LETTER_W-1:0] r_s1_idx;
  logic                r_rxerr_q, r_abort;

  state_t              r_state;
  logic                r_cfg_wr, r_cmd_err, r_drop;
  logic [2:0]          r_cfg_addr;
  logic [LETTER_W-1:0] r_cfg_data;

  logic                w_push, w_pop, w_full, w_empty, w_fifo_drop;
  logic [FIFO_AW:0]    w_count;
  logic [3:0]          w_fsel;

  assign w_fsel = field_sel(rx_byte);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld      <= 1'b0;
      r_s1_letter   <= 1'b0;
      r_s1_bang     <= 1'b0;
      r_s1_fld_ok   <= 1'b0;
      r_s1_fld_addr <= '0;
      r_s1_idx      <= '0;
      r_rxerr_q     <= 1'b0;
      r_abort       <= 1'b0;
    end else begin
      r_s1_vld      <= rx_valid;
      r_s1_letter   <= is_letter(rx_byte);
      r_s1_bang     <= (rx_byte == ASCII_BANG);
      r_s1_fld_ok   <= w_fsel[3];
      r_s1_fld_addr <= w_fsel[2:0];
      r_s1_idx      <= letter_idx(rx_byte);
      r_rxerr_q     <= rx_error;
      r_abort       <= rx_error && !r_rxerr_q;
    end
  end

  assign w_push      = r_s1_vld && r_s1_letter && (r_state == ST_IDLE);
  assign w_pop       = char_valid && char_ready;
  assign w_fifo_drop = w_push && w_full && !w_pop;
  assign char_valid  = !w_empty;

  char_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .W(LETTER_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (r_s1_idx),
    .pop   (w_pop),
    .rdata (char_data),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cfg_wr   <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_drop     <= 1'b0;
      r_cfg_addr <= '0;
      r_cfg_data <= '0;
    end else begin
      r_cfg_wr  <= 1'b0;
      r_cmd_err <= 1'b0;
      r_drop    <= w_fifo_drop;
      case (r_state)
        ST_IDLE:
          if (r_s1_vld && r_s1_bang) r_state <= ST_FIELD;
        ST_FIELD:
          if (r_s1_vld) begin
            if (r_s1_fld_ok) begin
              r_cfg_addr <= r_s1_fld_addr;
              r_state    <= ST_VALUE;
            end else begin
              r_cmd_err <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end
        ST_VALUE:
          if (r_s1_vld) begin
            if (r_s1_letter) begin
              r_cfg_data <= r_s1_idx;
              r_state    <= ST_APPLY;
            end else begin
              r_cmd_err <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end
        ST_APPLY: begin
          if (r_s1_vld) r_drop <= 1'b1;
          // Letters queued before the command must reach the core first
          if (w_count == '0 && !w_push) begin
            r_cfg_wr <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // The abort overrides whatever the byte in this cycle decided
      if (r_abort && (r_state == ST_FIELD || r_state == ST_VALUE))
        r_state <= ST_IDLE;
    end
  end

  assign cfg_wr      = r_cfg_wr;
  assign cfg_addr    = r_cfg_addr;
  assign cfg_data    = r_cfg_data;
  assign cmd_error   = r_cmd_err;
  assign drop_error  = r_drop;
  assign frame_error = r_abort;

endmodule

// File: tb/tb_enigma_cmd_parser.sv
// Scoreboard bench: stimulus pushes expected letters/config writes, a negedge
// monitor pops and compares them and tallies error pulses.
module tb_enigma_cmd_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_error = 1'b0;
  logic [4:0] char_data;
  logic       char_valid;
  logic       char_ready = 1'b1;
  logic       cfg_wr;
  logic [2:0] cfg_addr;
  logic [4:0] cfg_data;
  logic       cmd_error, drop_error, frame_error;

  always #5 clk = ~clk;

  enigma_cmd_parser #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_error(rx_error),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cmd_error(cmd_error), .drop_error(drop_error), .frame_error(frame_error)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_cmd = 0, n_drop = 0, n_frame = 0, n_cfg = 0;
  logic [4:0] exp_char[$];
  logic [7:0] exp_cfg[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (char_valid && char_ready) begin
        if (exp_char.size() == 0) chk("unexpected_char", 32'(char_data), 32'hFFFF);
        else chk("char_data", 32'(char_data), 32'(exp_char.pop_front()));
      end
      if (cfg_wr) begin
        n_cfg++;
        chk("cfg_after_letters", 32'(exp_char.size()), 0);
        if (exp_cfg.size() == 0) chk("unexpected_cfg", 32'({cfg_addr, cfg_data}), 32'hFFFF);
        else chk("cfg_addr_data", 32'({cfg_addr, cfg_data}), 32'(exp_cfg.pop_front()));
      end
      if (cmd_error)   n_cmd++;
      if (drop_error)  n_drop++;
      if (frame_error) n_frame++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  initial begin
    idle(2);
    chk("rst_char_valid", 32'(char_valid), 0);
    chk("rst_outputs", 32'({cfg_wr, cmd_error, drop_error, frame_error, cfg_addr, cfg_data}), 0);
    rst = 1'b0;
    idle(2);

    // "Hi": first char_valid two cycles after rx_valid
    exp_char.push_back(5'd7);
    exp_char.push_back(5'd8);
    send(8'h48);
    chk("hi_lat_n1", 32'(char_valid), 0);
    @(negedge clk);
    chk("hi_lat_n2", 32'(char_valid), 1);
    chk("hi_head", 32'(char_data), 7);
    send(8'h69);
    idle(4);
    chk("hi_drained", 32'(exp_char.size()), 0);

    // "!Mq" -> position M = 'q' (16)
    exp_cfg.push_back({3'd1, 5'd16});
    send_str("!Mq");
    idle(6);
    chk("mq_cfg_count", 32'(n_cfg), 1);
    chk("mq_no_char", 32'(char_valid), 0);
    chk("mq_errors", 32'(n_cmd + n_drop + n_frame), 0);

    // "AB!2C" with core stalled: cfg held behind letters
    char_ready = 1'b0;
    exp_char.push_back(5'd0);
    exp_char.push_back(5'd1);
    exp_cfg.push_back({3'd4, 5'd2});
    send_str("AB!2C");
    idle(8);
    chk("apply_held_cfg", 32'(n_cfg), 1);
    chk("apply_held_valid", 32'(char_valid), 1);
    char_ready = 1'b1;
    idle(8);
    chk("apply_released_cfg", 32'(n_cfg), 2);
    chk("apply_no_drop", 32'(n_drop), 0);

    // "ABCDE" into a 4-deep FIFO: only the 'E' is dropped
    char_ready = 1'b0;
    send_str("ABCD");
    idle(3);
    chk("full_no_drop_yet", 32'(n_drop), 0);
    send(8'h45);
    idle(3);
    chk("full_drop_on_E", 32'(n_drop), 1);
    for (int i = 0; i < 4; i++) exp_char.push_back(5'(i));
    char_ready = 1'b1;
    idle(8);
    chk("full_drained", 32'(exp_char.size()), 0);

    // Malformed commands
    send_str("!X");
    idle(3);
    chk("cmd_bad_field", 32'(n_cmd), 1);
    send_str("!R5");
    idle(3);
    chk("cmd_bad_value", 32'(n_cmd), 2);
    exp_char.push_back(5'd10);
    send(8'h4B);
    idle(4);
    chk("cmd_then_K", 32'(exp_char.size()), 0);

    // Frame error aborts a half-built command
    send_str("!L");
    @(negedge clk);
    rx_error = 1'b1;
    idle(3);
    rx_error = 1'b0;
    idle(2);
    chk("frame_pulse", 32'(n_frame), 1);
    exp_char.push_back(5'd25);
    send(8'h5A);
    idle(6);
    chk("frame_then_Z", 32'(exp_char.size()), 0);
    chk("frame_no_cfg", 32'(n_cfg), 2);

    chk("final_cmd_count", 32'(n_cmd), 2);
    chk("final_drop_count", 32'(n_drop), 1);
    chk("final_cfg_queue", 32'(exp_cfg.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
